// File: rtl/expr_check_arbiter.sv
// Two-requester front end for a shared single-pass expression recognizer: buffer, clear, stream, sample, respond.
// Optional statistics counters are built when EXPR_STATS_EN is defined.
module expr_check_arbiter #(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req0_valid,
   input  logic [7:0]       req0_data,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_data,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic             resp_match,
   output logic             resp_err,
   output logic             chk_clr,
   output logic [7:0]       chk_in,
   input  logic             chk_out,
   output logic             busy
`ifdef EXPR_STATS_EN
   ,
   output logic [CNT_W-1:0] cnt_match,
   output logic [CNT_W-1:0] cnt_reject,
   output logic [CNT_W-1:0] cnt_err
`endif
);

   localparam int unsigned    AW    = $clog2(MAX_LEN);
   localparam int unsigned    PW    = $clog2(MAX_LEN + 1);
   localparam logic [PW-1:0]  LEN_P = PW'(MAX_LEN);
   localparam logic [PW-1:0]  ONE_P = PW'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_CLEAR  = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_SAMPLE = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   if (MAX_LEN < 2 || MAX_LEN > 256 || CNT_W < 1) begin : g_cfg_check
      $error("expr_check_arbiter: MAX_LEN must be 2..256 and CNT_W must be >= 1");
   end

   logic [2:0]    state_q, state_d;
   logic          rr_next_q, rr_next_d;
   logic          grant_q, grant_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_match_q, resp_match_d;
   logic          resp_err_q, resp_err_d;
   logic          chk_clr_q, chk_clr_d;
   logic [7:0]    mem_q [MAX_LEN];
   logic          mem_we;

   logic          sel_valid;
   logic [7:0]    sel_data;
   logic          sel_last;
   logic          resp_hs;

   assign sel_valid = grant_q ? req1_valid : req0_valid;
   assign sel_data  = grant_q ? req1_data  : req0_data;
   assign sel_last  = grant_q ? req1_last  : req0_last;
   assign resp_hs   = resp_valid_q && resp_ready;

   always_comb begin
      state_d      = state_q;
      rr_next_d    = rr_next_q;
      grant_d      = grant_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ovf_d        = ovf_q;
      resp_match_d = resp_match_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant_d   = (req0_valid && req1_valid) ? rr_next_q : req1_valid;
               rr_next_d = ~grant_d;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (sel_valid) begin
               if (wr_ptr_q < LEN_P) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + ONE_P;
               end else begin
                  ovf_d = 1'b1;
               end
               // The closing byte itself may be the one that overflows.
               if (sel_last) begin
                  if (ovf_q || (wr_ptr_q == LEN_P)) begin
                     resp_match_d = 1'b0;
                     resp_err_d   = 1'b1;
                     state_d      = S_RESP;
                  end else begin
                     state_d = S_CLEAR;
                  end
               end
            end
         end
         S_CLEAR: begin
            rd_ptr_d = '0;
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            rd_ptr_d = rd_ptr_q + ONE_P;
            if (rd_ptr_q == (wr_ptr_q - ONE_P)) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            resp_match_d = chk_out;
            resp_err_d   = 1'b0;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (resp_hs) begin
               wr_ptr_d = '0;
               ovf_d    = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // resp_valid trails entry into RESP by one cycle; the recognizer stays out of clear through SAMPLE.
      resp_valid_d = (state_q == S_RESP) && !resp_hs;
      chk_clr_d    = !((state_d == S_STREAM) || (state_d == S_SAMPLE));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= S_IDLE;
         rr_next_q    <= 1'b0;
         grant_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_match_q <= 1'b0;
         resp_err_q   <= 1'b0;
         chk_clr_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         rr_next_q    <= rr_next_d;
         grant_q      <= grant_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_q        <= ovf_d;
         resp_valid_q <= resp_valid_d;
         resp_match_q <= resp_match_d;
         resp_err_q   <= resp_err_d;
         chk_clr_q    <= chk_clr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[AW-1:0]] <= sel_data;
      end
   end

   assign req0_ready = (state_q == S_LOAD) && !grant_q;
   assign req1_ready = (state_q == S_LOAD) &&  grant_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = grant_q;
   assign resp_match = resp_match_q;
   assign resp_err   = resp_err_q;
   assign chk_clr    = chk_clr_q;
   assign chk_in     = (state_q == S_STREAM) ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign busy       = (state_q != S_IDLE);

`ifdef EXPR_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_match_q, cnt_reject_q, cnt_err_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_match_q  <= '0;
         cnt_reject_q <= '0;
         cnt_err_q    <= '0;
      end else if (resp_hs) begin
         if (resp_err_q) begin
            if (cnt_err_q != '1) cnt_err_q <= cnt_err_q + CNT_ONE;
         end else if (resp_match_q) begin
            if (cnt_match_q != '1) cnt_match_q <= cnt_match_q + CNT_ONE;
         end else begin
            if (cnt_reject_q != '1) cnt_reject_q <= cnt_reject_q + CNT_ONE;
         end
      end
   end

   assign cnt_match  = cnt_match_q;
   assign cnt_reject = cnt_reject_q;
   assign cnt_err    = cnt_err_q;
`endif

endmodule
